// File: rtl/pwm_sine_multich.sv
// Multi-channel sine-modulated PWM generator.
// A shared R-bit counter defines the PWM period; every hold_n periods the
// sine-table step advances and each channel reloads its duty from the table
// at its own phase offset (or from duty_const in fixed-duty mode).
module pwm_sine_multich #(
   parameter int R  = 6,
   parameter int CH = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   input  logic [11:0]       hold_n,
   input  logic [R-1:0]      duty_const,
   input  logic [6*CH-1:0]   phase_off,
   output logic [CH-1:0]     pwm_out,
   output logic [5:0]        step_idx,
   output logic              period_tick
);

   localparam int SH = 10 - R;

   // Table duty for entry k: 10-bit sine sample scaled down to R bits.
   function automatic logic [R-1:0] table_duty(input logic [6:0] k);
      logic [9:0] s;
      case (k)
         7'd0:  s = 10'd512;   7'd1:  s = 10'd600;   7'd2:  s = 10'd687;
         7'd3:  s = 10'd768;   7'd4:  s = 10'd841;   7'd5:  s = 10'd904;
         7'd6:  s = 10'd955;   7'd7:  s = 10'd993;   7'd8:  s = 10'd1016;
         7'd9:  s = 10'd1023;  7'd10: s = 10'd1016;  7'd11: s = 10'd993;
         7'd12: s = 10'd955;   7'd13: s = 10'd904;   7'd14: s = 10'd841;
         7'd15: s = 10'd768;   7'd16: s = 10'd687;   7'd17: s = 10'd600;
         7'd18: s = 10'd512;   7'd19: s = 10'd423;   7'd20: s = 10'd336;
         7'd21: s = 10'd256;   7'd22: s = 10'd182;   7'd23: s = 10'd119;
         7'd24: s = 10'd68;    7'd25: s = 10'd30;    7'd26: s = 10'd7;
         7'd27: s = 10'd0;     7'd28: s = 10'd7;     7'd29: s = 10'd30;
         7'd30: s = 10'd68;    7'd31: s = 10'd119;   7'd32: s = 10'd182;
         7'd33: s = 10'd256;   7'd34: s = 10'd336;   7'd35: s = 10'd423;
         default: s = 10'd512;
      endcase
      return R'(s >> SH);
   endfunction

   // Table index (step + offset) mod 36; offsets of 36..63 fold back once.
   function automatic logic [6:0] wrap_idx(input logic [5:0] step, input logic [5:0] off);
      logic [6:0] off_r;
      logic [6:0] sum;
      off_r = (off >= 6'd36) ? ({1'b0, off} - 7'd36) : {1'b0, off};
      sum   = {1'b0, step} + off_r;
      if (sum >= 7'd36) begin
         sum = sum - 7'd36;
      end
      return sum;
   endfunction

   logic [R-1:0] q_q, q_d;
   logic [11:0]  n_q, n_d;
   logic [5:0]   step_q, step_d;
   logic [R-1:0] duty_q [CH];
   logic [R-1:0] duty_d [CH];
   logic [11:0]  hold_eff;
   logic         tick;

   // Last cycle of a running PWM period.
   always_comb begin
      tick = en & (q_q == '1);
   end

   // Next-state: counter, hold/step sequencer, duty reload on tick only.
   always_comb begin
      q_d      = q_q;
      n_d      = n_q;
      step_d   = step_q;
      duty_d   = duty_q;
      hold_eff = (hold_n == '0) ? 12'd1 : hold_n;
      if (en) begin
         q_d = q_q + 1'b1;
      end
      if (tick) begin
         if (n_q >= hold_eff - 12'd1) begin
            n_d    = '0;
            step_d = (step_q == 6'd35) ? '0 : step_q + 6'd1;
         end else begin
            n_d = n_q + 12'd1;
         end
         // Duty uses the post-update step so the new period starts on the new sample.
         for (int unsigned c = 0; c < CH; c++) begin
            duty_d[c] = mode ? duty_const : table_duty(wrap_idx(step_d, phase_off[6*c +: 6]));
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= '0;
         n_q    <= '0;
         step_q <= '0;
         duty_q <= '{default: '0};
      end else begin
         q_q    <= q_d;
         n_q    <= n_d;
         step_q <= step_d;
         duty_q <= duty_d;
      end
   end

   // PWM compare and status outputs.
   always_comb begin
      pwm_out = '0;
      for (int unsigned c = 0; c < CH; c++) begin
         pwm_out[c] = en & (q_q < duty_q[c]);
      end
      step_idx    = step_q;
      period_tick = tick;
   end

endmodule

// File: tb/tb_pwm_sine_multich.sv
// Bench for pwm_sine_multich (R=6, CH=3): a cycle-level reference model
// derived from the sine formula, compared on every falling edge, plus
// directed period measurements with hand-computed expectations.
module tb_pwm_sine_multich;

   localparam int R  = 6;
   localparam int CH = 3;
   localparam int P  = 1 << R;

   logic            clk;
   logic            rst;
   logic            en;
   logic            mode;
   logic [11:0]     hold_n;
   logic [R-1:0]    duty_const;
   logic [6*CH-1:0] phase_off;
   logic [CH-1:0]   pwm_out;
   logic [5:0]      step_idx;
   logic            period_tick;

   pwm_sine_multich #(.R(R), .CH(CH)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .mode        (mode),
      .hold_n      (hold_n),
      .duty_const  (duty_const),
      .phase_off   (phase_off),
      .pwm_out     (pwm_out),
      .step_idx    (step_idx),
      .period_tick (period_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference table built from the sine formula itself.
   int tblT [36];
   initial begin
      real s;
      int  v;
      for (int k = 0; k < 36; k++) begin
         s = 512.0 + 512.0 * $sin(2.0 * 3.14159265358979323846 * k / 36.0) + 1.0e-6;
         v = int'($floor(s));
         if (v > 1023) v = 1023;
         tblT[k] = v >> (10 - R);
      end
   end

   // Reference model: period counter, periods-per-step count, step, duties.
   int m_q = 0, m_n = 0, m_step = 0;
   int m_duty [CH];
   initial for (int c = 0; c < CH; c++) m_duty[c] = 0;

   always @(posedge clk) begin : model
      int h, st, idx;
      if (rst) begin
         m_q    <= 0;
         m_n    <= 0;
         m_step <= 0;
         for (int c = 0; c < CH; c++) m_duty[c] <= 0;
      end else if (en) begin
         m_q <= (m_q + 1) % P;
         if (m_q == P - 1) begin
            h = (hold_n == 0) ? 1 : int'(hold_n);
            if (m_n >= h - 1) begin
               m_n <= 0;
               st = (m_step + 1) % 36;
            end else begin
               m_n <= m_n + 1;
               st = m_step;
            end
            m_step <= st;
            for (int c = 0; c < CH; c++) begin
               idx = (st + int'(phase_off[6*c +: 6]) % 36) % 36;
               m_duty[c] <= mode ? int'(duty_const) : tblT[idx];
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin : compare
      logic [CH-1:0] e;
      if (chk_on) begin
         for (int c = 0; c < CH; c++) e[c] = en && (m_q < m_duty[c]);
         chk("cyc_pwm", int'(pwm_out), int'(e));
         chk("cyc_step", int'(step_idx), m_step);
         chk("cyc_tick", int'(period_tick), (en && m_q == P - 1) ? 1 : 0);
      end
   end

   int  mhi [CH];
   int  mtk, mstep;
   bit  mstable;

   // Sample one full period; optionally switch to fixed duty 16 at sample chg_at.
   task automatic measure_period(input int chg_at);
      for (int c = 0; c < CH; c++) mhi[c] = 0;
      mtk = 0;
      mstable = 1'b1;
      mstep = 0;
      for (int i = 0; i < P; i++) begin
         @(negedge clk);
         if (i == chg_at) begin
            mode = 1'b1;
            duty_const = 6'd16;
         end
         if (i == 0) mstep = int'(step_idx);
         for (int c = 0; c < CH; c++) if (pwm_out[c]) mhi[c]++;
         if (period_tick) mtk++;
         if (int'(step_idx) != mstep) mstable = 1'b0;
      end
   endtask

   task automatic check_period(input string nm, input int h0, input int h1, input int h2,
                               input int st);
      chk({nm, "_hi0"}, mhi[0], h0);
      chk({nm, "_hi1"}, mhi[1], h1);
      chk({nm, "_hi2"}, mhi[2], h2);
      chk({nm, "_ticks"}, mtk, 1);
      chk({nm, "_step"}, mstep, st);
      chk({nm, "_stable"}, int'(mstable), 1);
   endtask

   // Cycles until step_idx changes, bounded.
   task automatic wait_change(output int n);
      int s0;
      s0 = int'(step_idx);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (int'(step_idx) == s0 && n < 1000);
   endtask

   initial begin
      int n, wraps, prev, tk, nz, sbad, cnt;
      rst = 1'b1; en = 1'b1; mode = 1'b0; hold_n = 12'd2; duty_const = 6'd16;
      phase_off = {6'd27, 6'd9, 6'd0};
      #1;
      chk("tbl_T0", tblT[0], 32);
      chk("tbl_T9", tblT[9], 63);
      chk("tbl_T18", tblT[18], 32);
      chk("tbl_T27", tblT[27], 0);

      // Reset held three cycles with en=1.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk_on = 1'b1;
         chk("rst_pwm", int'(pwm_out), 0);
         chk("rst_step", int'(step_idx), 0);
         chk("rst_tick", int'(period_tick), 0);
      end
      rst = 1'b0;

      // First period dark; hold=2 keeps step 0 so duties come from T0/T9/T27.
      measure_period(-1); check_period("p1", 0, 0, 0, 0);
      measure_period(-1); check_period("p2", 32, 63, 0, 0);
      @(posedge clk); #1;
      hold_n = 12'd1;
      measure_period(-1); check_period("p3", 37, 63, 0, 1);
      measure_period(-1); check_period("p4", 42, 62, 1, 2);

      // hold_n=4: one step per 256 cycles, and a full table wrap.
      @(negedge clk);
      hold_n = 12'd4;
      wait_change(n); chk("hold4_a", n, 256);
      wait_change(n); chk("hold4_b", n, 256);
      chk("hold4_step", int'(step_idx), 5);
      wraps = 0;
      prev = int'(step_idx);
      repeat (36 * 256) begin
         @(negedge clk);
         if (prev == 35 && step_idx == 6'd0) wraps++;
         prev = int'(step_idx);
      end
      chk("wrap_cnt", wraps, 1);
      chk("wrap_step", int'(step_idx), 5);

      // hold_n=0 acts as 1.
      hold_n = 12'd0;
      wait_change(n); chk("hold0_a", n, 64);
      wait_change(n); chk("hold0_b", n, 64);
      chk("hold0_step", int'(step_idx), 7);

      // Enable low for 100 cycles at q=20.
      repeat (20) @(posedge clk);
      #1;
      en = 1'b0;
      tk = 0; nz = 0; sbad = 0;
      repeat (100) begin
         @(negedge clk);
         if (period_tick) tk++;
         if (pwm_out != '0) nz++;
         if (step_idx != 6'd7) sbad++;
      end
      chk("en0_ticks", tk, 0);
      chk("en0_pwm_high", nz, 0);
      chk("en0_step_moved", sbad, 0);
      @(posedge clk); #1;
      en = 1'b1;
      cnt = 0;
      for (int i = 1; i <= 200 && cnt == 0; i++) begin
         @(negedge clk);
         if (period_tick) cnt = i;
      end
      chk("en_tick_delay", cnt, 44);

      // Fixed duty requested at q=40: current period untouched.
      measure_period(40); check_period("mode_cur", 63, 37, 26, 8);
      measure_period(-1); check_period("mode_new", 16, 16, 16, 9);

      // Reset mid-run at step 20, q=30.
      repeat (10 * 64 + 31) @(posedge clk);
      #1;
      chk("pre_rst_step", int'(step_idx), 20);
      rst = 1'b1;
      mode = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst2_pwm", int'(pwm_out), 0);
         chk("rst2_step", int'(step_idx), 0);
         chk("rst2_tick", int'(period_tick), 0);
      end
      rst = 1'b0;
      measure_period(-1); check_period("r_p1", 0, 0, 0, 0);
      measure_period(-1); check_period("r_p2", 37, 63, 0, 1);

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
